// File: rtl/multisim_noc_bridge_pkg.sv
// multisim_noc_bridge_pkg: default parameters and id width helper for the noc bridge.
package multisim_noc_bridge_pkg;
    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_N_CPU       = 4;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_IDLE_CYCLES = 16;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/multisim_fifo.sv
// multisim_fifo: registered-output-latency FIFO, one cycle from write to visible head.
module multisim_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           cnt_q;
    logic                  do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop & ~empty;
    // a simultaneous pop frees the slot, so a full FIFO may also accept
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/multisim_noc_bridge.sv
// multisim_noc_bridge: per-channel FIFOs between server ports and a single noc link,
// round-robin c2n arbitration, n2c routing by id, and drain/quiet detection.
module multisim_noc_bridge
    import multisim_noc_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int N_CPU       = DEF_N_CPU,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    localparam int ID_W       = id_w(N_CPU)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CPU-1:0]            srv_c2n_vld,
    input  logic [N_CPU*DATA_WIDTH-1:0] srv_c2n_data,
    output logic [N_CPU-1:0]            srv_c2n_rdy,
    output logic                        noc_c2n_vld,
    output logic [DATA_WIDTH-1:0]       noc_c2n_data,
    output logic [ID_W-1:0]             noc_c2n_id,
    input  logic                        noc_c2n_rdy,
    input  logic                        noc_n2c_vld,
    input  logic [DATA_WIDTH-1:0]       noc_n2c_data,
    input  logic [ID_W-1:0]             noc_n2c_id,
    output logic                        noc_n2c_rdy,
    output logic [N_CPU-1:0]            srv_n2c_vld,
    output logic [N_CPU*DATA_WIDTH-1:0] srv_n2c_data,
    input  logic [N_CPU-1:0]            srv_n2c_rdy,
    output logic                        transactions_done,
    output logic                        bad_id_err
);
    localparam int OW = $clog2(2*FIFO_DEPTH*N_CPU+1);
    localparam int IW = $clog2(IDLE_CYCLES+1);

    logic [N_CPU-1:0]                 c2n_full, c2n_empty, c2n_pop;
    logic [N_CPU-1:0]                 n2c_full, n2c_empty, n2c_push;
    logic [N_CPU-1:0][DATA_WIDTH-1:0] c2n_head, n2c_head;
    logic [N_CPU-1:0][OW-1:0]         out_q, out_d;
    logic [ID_W-1:0]                  rr_q, rr_d, lock_id_q, lock_id_d, grant;
    logic                             lock_q, lock_d;
    logic [IW-1:0]                    idle_q, idle_d;
    logic                             done_q, done_d, bad_q, bad_d;
    logic                             id_ok, c2n_acc, n2c_acc, any_hs;

    for (genvar c = 0; c < N_CPU; c++) begin : g_ch
        multisim_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_c2n (
            .clk(clk), .rst(rst),
            .push(srv_c2n_vld[c] & srv_c2n_rdy[c]),
            .wdata(srv_c2n_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop(c2n_pop[c]), .rdata(c2n_head[c]),
            .full(c2n_full[c]), .empty(c2n_empty[c])
        );
        multisim_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_n2c (
            .clk(clk), .rst(rst),
            .push(n2c_push[c]), .wdata(noc_n2c_data),
            .pop(srv_n2c_vld[c] & srv_n2c_rdy[c]), .rdata(n2c_head[c]),
            .full(n2c_full[c]), .empty(n2c_empty[c])
        );
        assign c2n_pop[c]  = c2n_acc && grant == ID_W'(c);
        assign n2c_push[c] = n2c_acc && id_ok && noc_n2c_id == ID_W'(c);
        assign srv_n2c_data[c*DATA_WIDTH +: DATA_WIDTH] = n2c_head[c];
    end

    assign id_ok             = int'(noc_n2c_id) < N_CPU;
    assign srv_c2n_rdy       = rst ? '0 : ~c2n_full;
    assign srv_n2c_vld       = ~n2c_empty;
    assign noc_c2n_vld       = ~&c2n_empty;
    assign noc_c2n_data      = c2n_head[grant];
    assign noc_c2n_id        = grant;
    // out-of-range ids are always accepted so they can be dropped
    assign noc_n2c_rdy       = rst ? 1'b0 : (id_ok ? ~n2c_full[noc_n2c_id] : 1'b1);
    assign c2n_acc           = noc_c2n_vld & noc_c2n_rdy;
    assign n2c_acc           = noc_n2c_vld & noc_n2c_rdy;
    assign any_hs            = |(srv_c2n_vld & srv_c2n_rdy) | c2n_acc | n2c_acc | |(srv_n2c_vld & srv_n2c_rdy);
    assign transactions_done = done_q;
    assign bad_id_err        = bad_q;

    // a stalled beat locks the grant so a newly filled channel cannot steal it
    always_comb begin
        grant = lock_q ? lock_id_q : rr_q;
        if (!lock_q)
            for (int i = N_CPU-1; i >= 0; i--)
                if (!c2n_empty[(int'(rr_q)+i) % N_CPU]) grant = ID_W'((int'(rr_q)+i) % N_CPU);
        rr_d      = c2n_acc ? ((int'(grant) == N_CPU-1) ? '0 : grant + 1'b1) : rr_q;
        lock_d    = noc_c2n_vld & ~noc_c2n_rdy;
        lock_id_d = grant;
    end

    always_comb begin
        for (int k = 0; k < N_CPU; k++) begin
            out_d[k] = out_q[k];
            if (c2n_pop[k] && !n2c_push[k] && out_q[k] != '1) out_d[k] = out_q[k] + 1'b1;
            else if (n2c_push[k] && !c2n_pop[k] && out_q[k] != '0) out_d[k] = out_q[k] - 1'b1;
        end
        idle_d = any_hs ? '0 : ((idle_q == IW'(IDLE_CYCLES)) ? idle_q : idle_q + 1'b1);
        done_d = &c2n_empty && &n2c_empty && out_q == '0 && idle_q == IW'(IDLE_CYCLES);
        bad_d  = bad_q | (noc_n2c_vld & ~id_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            out_q     <= '0;
            idle_q    <= '0;
            done_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            out_q     <= out_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            bad_q     <= bad_d;
        end
    end
endmodule

// File: tb/tb_multisim_noc_bridge.sv
// tb_multisim_noc_bridge: directed checks of arbitration, routing, backpressure, done and reset.
module tb_multisim_noc_bridge;
    logic         clk = 1'b0, rst = 1'b1;
    logic [3:0]   c2n_vld, c2n_rdy, sn_vld, sn_rdy;
    logic [255:0] c2n_data, sn_data;
    logic         nc_vld, nc_rdy, nn_vld, nn_rdy, done, bad;
    logic [63:0]  nc_data, nn_data;
    logic [1:0]   nc_id, nn_id;

    logic [4:0]   b_c2n_vld, b_c2n_rdy, b_sn_vld;
    logic [39:0]  b_c2n_data, b_sn_data;
    logic         b_nc_vld, b_nn_vld, b_nn_rdy, b_done, b_bad;
    logic [7:0]   b_nc_data;
    logic [2:0]   b_nc_id, b_nn_id;

    int n_chk = 0, n_err = 0, acc;
    logic [1:0] rr_ids [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    always #5 clk = ~clk;

    multisim_noc_bridge u_dut (
        .clk(clk), .rst(rst),
        .srv_c2n_vld(c2n_vld), .srv_c2n_data(c2n_data), .srv_c2n_rdy(c2n_rdy),
        .noc_c2n_vld(nc_vld), .noc_c2n_data(nc_data), .noc_c2n_id(nc_id), .noc_c2n_rdy(nc_rdy),
        .noc_n2c_vld(nn_vld), .noc_n2c_data(nn_data), .noc_n2c_id(nn_id), .noc_n2c_rdy(nn_rdy),
        .srv_n2c_vld(sn_vld), .srv_n2c_data(sn_data), .srv_n2c_rdy(sn_rdy),
        .transactions_done(done), .bad_id_err(bad)
    );

    // five channels need a 3-bit id, so id 7 is representable and out of range
    multisim_noc_bridge #(.DATA_WIDTH(8), .N_CPU(5), .FIFO_DEPTH(2), .IDLE_CYCLES(1)) u_small (
        .clk(clk), .rst(rst),
        .srv_c2n_vld(b_c2n_vld), .srv_c2n_data(b_c2n_data), .srv_c2n_rdy(b_c2n_rdy),
        .noc_c2n_vld(b_nc_vld), .noc_c2n_data(b_nc_data), .noc_c2n_id(b_nc_id), .noc_c2n_rdy(1'b1),
        .noc_n2c_vld(b_nn_vld), .noc_n2c_data(8'h3C), .noc_n2c_id(b_nn_id), .noc_n2c_rdy(b_nn_rdy),
        .srv_n2c_vld(b_sn_vld), .srv_n2c_data(b_sn_data), .srv_n2c_rdy(5'h1F),
        .transactions_done(b_done), .bad_id_err(b_bad)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        c2n_vld = '0; c2n_data = '0; nc_rdy = 1'b0; nn_vld = 1'b0; nn_data = '0; nn_id = '0; sn_rdy = '1;
        b_c2n_vld = '0; b_c2n_data = '0; b_nn_vld = 1'b0; b_nn_id = '0;
        repeat (2) step();
        chk("rst_c2n_rdy", c2n_rdy, 0);
        chk("rst_n2c_rdy", nn_rdy, 0);
        chk("rst_nc_vld", nc_vld, 0);
        chk("rst_sn_vld", sn_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_bad", bad, 0);
        rst = 1'b0;
        step();
        chk("c2n_rdy_idle", c2n_rdy, 4'hF);

        for (int j = 0; j < 2; j++) begin
            c2n_vld = 4'b1011;
            for (int c = 0; c < 4; c++) c2n_data[c*64 +: 64] = 64'(c*256 + j);
            step();
        end
        c2n_vld = '0;
        chk("rr_stall_id", nc_id, 0);
        step();
        chk("rr_hold_id", nc_id, 0);
        nc_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_vld", nc_vld, 1);
            chk("rr_id", nc_id, rr_ids[k]);
            chk("rr_data", nc_data, 64'(rr_ids[k]*256 + k/3));
            step();
        end
        chk("rr_empty", nc_vld, 0);

        c2n_vld = 4'b0100; c2n_data[128 +: 64] = 64'hA5;
        chk("single_no_fwft", nc_vld, 0);
        step();
        c2n_vld = '0;
        chk("single_vld", nc_vld, 1);
        chk("single_id", nc_id, 2);
        chk("single_data", nc_data, 64'hA5);
        step();
        chk("single_gone", nc_vld, 0);

        nn_vld = 1'b1; nn_id = 2'd2; nn_data = 64'h5A; sn_rdy = '0;
        chk("resp_rdy", nn_rdy, 1);
        step();
        nn_vld = 1'b0;
        chk("resp2_vld", sn_vld, 4'b0100);
        chk("resp2_data", sn_data[128 +: 64], 64'h5A);
        sn_rdy = '1;
        step();
        chk("resp2_popped", sn_vld, 0);

        nc_rdy = 1'b0; acc = 0;
        for (int j = 0; j < 5; j++) begin
            c2n_vld = 4'b0010; c2n_data[64 +: 64] = 64'(512 + j);
            if (j == 4) chk("bp_full_rdy", c2n_rdy[1], 0);
            if (c2n_rdy[1]) acc++;
            step();
        end
        c2n_vld = '0;
        chk("bp_accepted", 64'(acc), 4);
        nc_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_id", nc_id, 1);
            chk("bp_data", nc_data, 64'(512 + j));
            step();
        end
        chk("bp_drained", nc_vld, 0);

        nn_vld = 1'b1; nn_id = 2'd3; nn_data = 64'h11; sn_rdy = '0;
        step();
        nn_vld = 1'b0;
        chk("resp3_vld", sn_vld, 4'b1000);
        chk("resp3_data", sn_data[192 +: 64], 64'h11);
        sn_rdy = '1;
        step();

        b_nn_vld = 1'b1; b_nn_id = 3'd7;
        chk("bad_rdy", b_nn_rdy, 1);
        step();
        b_nn_vld = 1'b0;
        chk("bad_set", b_bad, 1);
        chk("bad_dropped", b_sn_vld, 0);
        step();
        chk("bad_sticky", b_bad, 1);
        chk("main_no_bad", bad, 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        c2n_vld = 4'b0001; c2n_data[0 +: 64] = 64'h77; nc_rdy = 1'b1;
        step();
        c2n_vld = '0;
        step();
        nn_vld = 1'b1; nn_id = 2'd0; nn_data = 64'h88;
        step();
        nn_vld = 1'b0;
        step();
        chk("done_busy", done, 0);
        repeat (16) step();
        chk("done_early", done, 0);
        step();
        chk("done_set", done, 1);
        c2n_vld = 4'b0001;
        step();
        c2n_vld = '0;
        step();
        chk("done_cleared", done, 0);

        nc_rdy = 1'b0; sn_rdy = '0; c2n_vld = 4'hF;
        repeat (4) step();
        nn_vld = 1'b1; nn_id = 2'd0;
        repeat (4) step();
        chk("mid_full", c2n_rdy, 0);
        chk("mid_sn_vld", sn_vld, 4'b0001);
        chk("mid_n2c_full", nn_rdy, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_nc_vld", nc_vld, 0);
        chk("mid_rst_sn_vld", sn_vld, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rdy", c2n_rdy, 0);
        c2n_vld = '0; nn_vld = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_nc_vld", nc_vld, 0);
        chk("post_sn_vld", sn_vld, 0);
        chk("post_rdy", c2n_rdy, 4'hF);
        nc_rdy = 1'b1; c2n_vld = 4'b1000; c2n_data[192 +: 64] = 64'h33;
        step();
        c2n_vld = '0;
        chk("restart_id", nc_id, 3);
        chk("restart_data", nc_data, 64'h33);
        step();
        chk("restart_empty", nc_vld, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
